// File: rtl/time_date_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// time_date_counter: prescaled 1 s clock/calendar with sanitized load handshake and alarm ringer
// Rev 1.0
// ----------------------------------------------------------------------------
module time_date_counter #(
  parameter int TICK_DIV  = 1000000,
  parameter int RING_SECS = 30
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [5:0]  MODE,
  input  logic        SETTING,
  input  logic        ALARM_SETTING,
  input  logic [16:0] OUT_TIME,
  input  logic [15:0] OUT_DATE,
  input  logic [16:0] OUT_ALARM_TIME,
  input  logic        ALARM_ENABLE,
  output logic [16:0] IN_TIME,
  output logic [15:0] IN_DATE,
  output logic [16:0] IN_ALARM_TIME,
  output logic        SETTING_OK,
  output logic        SEC_TICK,
  output logic        ALARM_RING
);

  localparam int c_pw = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_rw = $clog2(RING_SECS + 1);
  localparam logic [c_pw-1:0] c_presc_max = c_pw'(TICK_DIV - 1);
  localparam logic [c_rw-1:0] c_ring_load = c_rw'(RING_SECS);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_ack  = 2'd1;
  localparam logic [1:0] c_st_hold = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [c_pw-1:0] r_presc;
  logic [c_rw-1:0] r_ring_cnt;
  logic [16:0]     r_time;
  logic [15:0]     r_date;
  logic [16:0]     r_alarm;
  logic            r_tick;
  logic            w_load_time;
  logic            w_load_alarm;
  logic            w_tick_due;
  logic [16:0]     w_time_inc;
  logic [15:0]     w_date_inc;
  logic [4:0]      w_dmax;
  logic            w_unused_mode;

  // Only the stop bit of the key-controller mode word matters here.
  assign w_unused_mode = ^MODE[5:1];

  function automatic logic [4:0] f_days_in_month(input logic [3:0] month, input logic [6:0] year);
    case (month)
      4'd2:                    f_days_in_month = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: f_days_in_month = 5'd30;
      default:                 f_days_in_month = 5'd31;
    endcase
  endfunction

  function automatic logic [16:0] f_san_time(input logic [16:0] t);
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    h = (t[16:12] > 5'd23) ? 5'd0 : t[16:12];
    m = (t[11:6] > 6'd59) ? 6'd0 : t[11:6];
    s = (t[5:0] > 6'd59) ? 6'd0 : t[5:0];
    return {h, m, s};
  endfunction

  // Day clamp uses the already-corrected month so Feb 30 lands on 28/29.
  function automatic logic [15:0] f_san_date(input logic [15:0] d);
    logic [3:0] mo;
    logic [4:0] dy;
    logic [4:0] mx;
    mo = ((d[8:5] == 4'd0) || (d[8:5] > 4'd12)) ? 4'd1 : d[8:5];
    mx = f_days_in_month(mo, d[15:9]);
    dy = d[4:0];
    if (dy == 5'd0)
      dy = 5'd1;
    else if (dy > mx)
      dy = mx;
    return {d[15:9], mo, dy};
  endfunction

  assign w_tick_due = ~MODE[0] & (r_presc == c_presc_max);

  always_comb begin
    w_time_inc = r_time;
    w_date_inc = r_date;
    w_dmax     = f_days_in_month(r_date[8:5], r_date[15:9]);
    if (r_time[5:0] != 6'd59) begin
      w_time_inc[5:0] = r_time[5:0] + 6'd1;
    end else begin
      w_time_inc[5:0] = 6'd0;
      if (r_time[11:6] != 6'd59) begin
        w_time_inc[11:6] = r_time[11:6] + 6'd1;
      end else begin
        w_time_inc[11:6] = 6'd0;
        if (r_time[16:12] != 5'd23) begin
          w_time_inc[16:12] = r_time[16:12] + 5'd1;
        end else begin
          w_time_inc[16:12] = 5'd0;
          if (r_date[4:0] < w_dmax) begin
            w_date_inc[4:0] = r_date[4:0] + 5'd1;
          end else begin
            w_date_inc[4:0] = 5'd1;
            if (r_date[8:5] < 4'd12) begin
              w_date_inc[8:5] = r_date[8:5] + 4'd1;
            end else begin
              w_date_inc[8:5]  = 4'd1;
              w_date_inc[15:9] = (r_date[15:9] == 7'd99) ? 7'd0 : r_date[15:9] + 7'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      r_state <= c_st_idle;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (SETTING | ALARM_SETTING) w_state_nxt = c_st_ack;
      c_st_ack:  w_state_nxt = c_st_hold;
      c_st_hold: if (!SETTING && !ALARM_SETTING) w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_load_time  = 1'b0;
    w_load_alarm = 1'b0;
    SETTING_OK   = 1'b0;
    case (r_state)
      c_st_idle: begin
        w_load_time  = SETTING;
        w_load_alarm = ALARM_SETTING;
      end
      c_st_ack: SETTING_OK = 1'b1;
      default: ;
    endcase
  end

  // A time load restarts the second and swallows any tick due on the same edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_time  <= 17'd0;
      r_date  <= {7'd0, 4'd1, 5'd1};
      r_alarm <= 17'd0;
    end else begin
      if (w_load_time || MODE[0] || w_tick_due)
        r_presc <= '0;
      else
        r_presc <= r_presc + 1'b1;
      r_tick <= w_tick_due & ~w_load_time;
      if (w_load_time) begin
        r_time <= f_san_time(OUT_TIME);
        r_date <= f_san_date(OUT_DATE);
      end else if (w_tick_due) begin
        r_time <= w_time_inc;
        r_date <= w_date_inc;
      end
      if (w_load_alarm)
        r_alarm <= f_san_time(OUT_ALARM_TIME);
    end
  end

  // Match is evaluated on the freshly advanced time, one cycle after the tick.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      r_ring_cnt <= '0;
    else if (!ALARM_ENABLE)
      r_ring_cnt <= '0;
    else if (r_tick && (r_time == r_alarm))
      r_ring_cnt <= c_ring_load;
    else if (r_tick && (r_ring_cnt != '0))
      r_ring_cnt <= r_ring_cnt - 1'b1;
  end

  assign IN_TIME       = r_time;
  assign IN_DATE       = r_date;
  assign IN_ALARM_TIME = r_alarm;
  assign SEC_TICK      = r_tick;
  assign ALARM_RING    = (r_ring_cnt != '0);

endmodule
`default_nettype wire

// File: doc/time_date_counter.md
TIME_DATE_COUNTER -- requirements
Module: time_date_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, CLK cycles per 1 s tick.
REQ-002 SHALL have parameter RING_SECS, default 30, alarm ring duration in seconds.
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  reset; one clock, asynchronous, active-high.
REQ-005 SHALL have port MODE  input  6  mode from key controller; only bit 0 is used (1 = counting stopped).
REQ-006 SHALL have port SETTING  input  1  level request to load OUT_TIME/OUT_DATE.
REQ-007 SHALL have port ALARM_SETTING  input  1  level request to load OUT_ALARM_TIME.
REQ-008 SHALL have port OUT_TIME  input  17  candidate time: hour[16:12], min[11:6], sec[5:0].
REQ-009 SHALL have port OUT_DATE  input  16  candidate date: year[15:9] (0-99), month[8:5], day[4:0].
REQ-010 SHALL have port OUT_ALARM_TIME  input  17  candidate alarm time, same layout as OUT_TIME.
REQ-011 SHALL have port ALARM_ENABLE  input  1  alarm armed.
REQ-012 SHALL have port IN_TIME  output  17  running time, registered.
REQ-013 SHALL have port IN_DATE  output  16  running date, registered.
REQ-014 SHALL have port IN_ALARM_TIME  output  17  stored alarm time, registered.
REQ-015 SHALL have port SETTING_OK  output  1  one-cycle load acknowledge.
REQ-016 SHALL have port SEC_TICK  output  1  one-cycle pulse per applied second.
REQ-017 SHALL have port ALARM_RING  output  1  alarm active.

Function
REQ-018 Prescaler SHALL count 0..TICK_DIV-1 while MODE[0]=0; SEC_TICK SHALL pulse in the cycle after the count reaches TICK_DIV-1, then the count SHALL wrap to 0.
REQ-019 While MODE[0]=1, the prescaler SHALL hold at 0, no tick SHALL occur, and IN_TIME/IN_DATE SHALL freeze.
REQ-020 Each tick SHALL advance the time as follows: sec 59->0 carries to min; min 59->0 carries to hour; hour 23->0 carries to day.
REQ-021 Day SHALL wrap max->1 with carry to month, where max is 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; 29 for month 2 when year%4=0, else 28.
REQ-022 Month 12->1 SHALL carry to year; year 99->0 SHALL wrap with no further carry.
REQ-023 The load FSM SHALL have three states: IDLE, ACK, HOLD.
REQ-024 In IDLE with SETTING=1: on the same edge, IN_TIME<=sanitized OUT_TIME, IN_DATE<=sanitized OUT_DATE, and the prescaler SHALL clear to 0.
REQ-025 In IDLE with ALARM_SETTING=1: on the same edge, IN_ALARM_TIME<=sanitized OUT_ALARM_TIME.
REQ-026 In IDLE with SETTING=1 or ALARM_SETTING=1 (including both together): both applicable loads SHALL occur and the FSM SHALL go to ACK.
REQ-027 In ACK, SETTING_OK SHALL be 1 for exactly one cycle, then the FSM SHALL go to HOLD.
REQ-028 In HOLD, the FSM SHALL stay until SETTING=0 and ALARM_SETTING=0, then return to IDLE; no reload SHALL occur in HOLD.
REQ-029 A load SHALL take priority over a tick coinciding in the same cycle; that tick SHALL be discarded.
REQ-030 Sanitizing SHALL apply these rules: hour>23 -> 0; min or sec >59 -> 0; month 0 or >12 -> 1; day 0 -> 1; day>max (using the loaded month/year) -> max.
REQ-031 In the cycle after SEC_TICK, if ALARM_ENABLE=1 and IN_TIME==IN_ALARM_TIME, the ring counter SHALL load RING_SECS and ALARM_RING SHALL become 1.
REQ-032 Each later SEC_TICK SHALL decrement the ring counter; ALARM_RING SHALL be 1 exactly while the counter is nonzero.
REQ-033 ALARM_ENABLE=0 SHALL clear the ring counter and ALARM_RING on the next edge.
REQ-034 An alarm match while already ringing SHALL reload the ring counter to RING_SECS.
REQ-035 A time load that equals the alarm time SHALL NOT trigger ringing; only ticks trigger it.

Reset
REQ-036 While RESET=1, the following SHALL hold immediately and asynchronously: IN_TIME=0; IN_DATE={7'd0,4'd1,5'd1}; IN_ALARM_TIME=0; SETTING_OK=0; SEC_TICK=0; ALARM_RING=0; prescaler=0; ring counter=0; FSM=IDLE.
REQ-037 Reset asserted mid-handshake or mid-ring SHALL abort the handshake or ring with no SETTING_OK pulse; after release, the block SHALL resume from the reset values.

Verification (TICK_DIV=4, RING_SECS=3)
REQ-038 Scenario: time 23:59:59, date 99/12/31, one tick -> IN_TIME 0, IN_DATE {0,1,1}.
REQ-039 Scenario: date 23/02/28 and 24/02/28 at 23:59:59, one tick -> 23/03/01 and 24/02/29 respectively.
REQ-040 Scenario: SETTING=1 held 5 cycles with OUT_TIME 25:61:10, OUT_DATE 05/02/30 -> IN_TIME 00:00:10, IN_DATE 05/02/28, exactly one SETTING_OK pulse, one cycle after the load edge.
REQ-041 Scenario: SETTING and ALARM_SETTING both raised the same cycle that a tick is due -> both registers loaded, tick dropped, one SETTING_OK pulse.
REQ-042 Scenario: MODE[0]=1 for 20 cycles -> no SEC_TICK and IN_TIME unchanged; on MODE[0]=0, the first tick comes 4 cycles later.
REQ-043 Scenario: alarm 00:00:02, enabled, count from 0 -> ALARM_RING rises after the 2nd tick, falls after 3 more ticks; ALARM_ENABLE=0 mid-ring -> ALARM_RING is 0 next cycle.
